// File: rtl/persp_divide.sv
// persp_divide -- perspective divide for one clip-space vertex at a time.
//
// Converts (x, y, z, w) clip coordinates into NDC (x/w, y/w, z/w) in signed
// fixed point with FRACT fractional bits. The reciprocal 2^(2*FRACT)/w is
// built by a radix-2 restoring divider (2*FRACT+1 quotient bits, one per
// cycle), then a single multiply cycle scales x, y and z by it. Vertices with
// w <= 0 skip the arithmetic and are flagged with cull.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_in / ready_in      vertex handshake (ready_in high only in IDLE)
//   x_clip..w_clip           signed clip coordinates, WIDTH bits each
//   valid_out / ready_out    result handshake towards the viewport stage
//   x_ndc, y_ndc, z_ndc      signed NDC result, WIDTH bits each
//   cull                     vertex had w <= 0 (qualified by valid_out)
//
// Configuration macro:
//   PERSP_DIVIDE_SATURATE_EN  clamp each scaled product to the signed WIDTH
//                             range; when undefined, the low WIDTH bits wrap.

module persp_divide #(
  parameter int WIDTH = 32,
  parameter int FRACT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic signed [WIDTH-1:0] x_clip,
  input  logic signed [WIDTH-1:0] y_clip,
  input  logic signed [WIDTH-1:0] z_clip,
  input  logic signed [WIDTH-1:0] w_clip,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic signed [WIDTH-1:0] x_ndc,
  output logic signed [WIDTH-1:0] y_ndc,
  output logic signed [WIDTH-1:0] z_ndc,
  output logic                    cull
);

  // Quotient of 2^(2*FRACT) / w needs 2*FRACT+1 bits (w = 1 gives 2^(2*FRACT)).
  localparam int QB   = 2 * FRACT + 1;
  localparam int CW   = $clog2(QB + 1);
  localparam int CMPW = (QB > WIDTH) ? QB : WIDTH;
  localparam logic [CW-1:0]   CNT_LAST   = CW'(QB - 1);
  localparam logic [CMPW-1:0] RECIP_MAX  = CMPW'({1'b0, {(WIDTH-1){1'b1}}});

  typedef enum logic [1:0] {IDLE, DIV, MUL, OUT} state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] x_r, y_r, z_r;
  logic        [WIDTH-1:0] w_r;
  logic        [WIDTH:0]   rem_q;
  logic        [QB-1:0]    quo_q;
  logic        [CW-1:0]    cnt_q;

  logic w_pos;
  assign w_pos = !w_clip[WIDTH-1] && (w_clip != '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d   = state_q;
    ready_in  = 1'b0;
    valid_out = 1'b0;
    case (state_q)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) state_d = w_pos ? DIV : OUT;
      end
      DIV:  if (cnt_q == CNT_LAST) state_d = MUL;
      MUL:  state_d = OUT;
      OUT: begin
        valid_out = 1'b1;
        if (ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------ divider step
  // The dividend is 2^(2*FRACT): its only set bit enters on the first step.
  logic [WIDTH:0] rem_shift, rem_next;
  logic           rem_ge;

  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], (cnt_q == '0)};
    rem_ge    = rem_shift >= {1'b0, w_r};
    rem_next  = rem_ge ? (rem_shift - {1'b0, w_r}) : rem_shift;
  end

  // Reciprocal saturated to the largest positive WIDTH-bit value.
  logic [CMPW-1:0]  quo_ext;
  logic [WIDTH-1:0] recip;

  always_comb begin
    quo_ext = CMPW'(quo_q);
    recip   = (quo_ext > RECIP_MAX) ? RECIP_MAX[WIDTH-1:0] : quo_ext[WIDTH-1:0];
  end

  // ---------------------------------------------------------- multiply
  localparam logic signed [2*WIDTH-1:0] SMAX = (2*WIDTH)'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [2*WIDTH-1:0] SMIN = ~SMAX;

  function automatic logic [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] v,
                                             input logic        [WIDTH-1:0] r);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{v[WIDTH-1]}}, v}) * $signed({{WIDTH{1'b0}}, r});
    p = p >>> FRACT;
`ifdef PERSP_DIVIDE_SATURATE_EN
    if (p > SMAX)      p = SMAX;
    else if (p < SMIN) p = SMIN;
`endif
    return p[WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      w_r   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      x_ndc <= '0;
      y_ndc <= '0;
      z_ndc <= '0;
      cull  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (valid_in) begin
          x_r   <= x_clip;
          y_r   <= y_clip;
          z_r   <= z_clip;
          w_r   <= w_clip;
          rem_q <= '0;
          quo_q <= '0;
          cnt_q <= '0;
          cull  <= !w_pos;
          if (!w_pos) begin
            x_ndc <= '0;
            y_ndc <= '0;
            z_ndc <= '0;
          end
        end
        DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[QB-2:0], rem_ge};
          cnt_q <= cnt_q + 1'b1;
        end
        MUL: begin
          x_ndc <= scale(x_r, recip);
          y_ndc <= scale(y_r, recip);
          z_ndc <= scale(z_r, recip);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/persp_divide.md
PERSP_DIVIDE -- requirements
Module: persp_divide

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter FRACT, default 16, fractional bits (Q16.16 at defaults).
REQ-003 SHALL have clk  input  1  clock; all state changes on posedge clk.
REQ-004 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have valid_in  input  1  clip-space vertex present.
REQ-006 SHALL have ready_in  output  1  block can accept a vertex.
REQ-007 SHALL have x_clip, y_clip, z_clip, w_clip  input  WIDTH each  signed clip coordinates.
REQ-008 SHALL have valid_out  output  1  NDC result present.
REQ-009 SHALL have ready_out  input  1  downstream (viewport stage) accepts the result.
REQ-010 SHALL have x_ndc, y_ndc, z_ndc  output  WIDTH each  signed NDC result.
REQ-011 SHALL have cull  output  1  vertex has w_clip <= 0; qualified by valid_out.

Function
REQ-012 SHALL implement FSM IDLE, DIV, MUL, OUT.
REQ-013 SHALL drive ready_in high only in IDLE.
REQ-014 SHALL accept a vertex on the edge where valid_in && ready_in; inputs captured into internal registers; later input changes have no effect on that vertex.
REQ-015 SHALL, on accept with w_clip > 0: IDLE->DIV; cull=0.
REQ-016 SHALL, on accept with w_clip <= 0: IDLE->OUT with x_ndc=y_ndc=z_ndc=0, cull=1; valid_out high 1 cycle after the accept edge.
REQ-017 SHALL, in DIV, compute recip = floor(2^(2*FRACT) / w) with a radix-2 restoring divider, one quotient bit per cycle, exactly 33 cycles (33-bit quotient).
REQ-018 SHALL saturate recip to 2^(WIDTH-1)-1 when the quotient exceeds it (e.g. w = 1 LSB).
REQ-019 SHALL, in MUL (1 cycle), form the 2*WIDTH-bit signed products of x, y, z with recip, arithmetic-shift right by FRACT (truncate toward -inf), and register the low WIDTH bits into the outputs; then go to OUT.
REQ-020 SHALL assert valid_out exactly 35 cycles after the accept edge for w_clip > 0.
REQ-021 SHALL, in OUT, hold valid_out, x_ndc, y_ndc, z_ndc and cull stable while ready_out is low.
REQ-022 SHALL, on an OUT edge with ready_out high, deassert valid_out and go to IDLE; ready_in is high the next cycle; data outputs keep their last values.
REQ-023 SHALL never accept a new vertex in the same cycle as the output handshake; throughput is one vertex per 36 cycles minimum.
REQ-024 SHALL ignore valid_in outside IDLE.

Reset
REQ-025 SHALL, while rst is high, force state IDLE, valid_out=0, cull=0, x_ndc=y_ndc=z_ndc=0, divider registers=0; ready_in=1 in the first cycle after rst deasserts.
REQ-026 SHALL discard any in-flight vertex on rst, in any state including mid-DIV; no valid_out for that vertex.

Configuration
REQ-027 SHALL support macro PERSP_DIVIDE_SATURATE_EN.
REQ-028 SHALL, with PERSP_DIVIDE_SATURATE_EN defined, clamp each shifted product to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before truncation to WIDTH bits.
REQ-029 SHALL, without PERSP_DIVIDE_SATURATE_EN, take the low WIDTH bits of each shifted product (wrap), with no clamp logic.

Verification
REQ-030 SHALL cover: w=0x00010000, x=0x00008000, y=0, z=0x00010000, ready_out=1 -> valid_out at accept+35 with x_ndc=0x00008000, y_ndc=0, z_ndc=0x00010000, cull=0.
REQ-031 SHALL cover: w=0x00020000, x=0x00010000, y=0xFFFF0000, z=0x00008000 -> x_ndc=0x00008000, y_ndc=0xFFFF8000, z_ndc=0x00004000.
REQ-032 SHALL cover: w=0 and w=0xFFFF0000 -> valid_out at accept+1, cull=1, all NDC outputs 0.
REQ-033 SHALL cover: ready_out low for 5 cycles after valid_out rises -> outputs and cull stable, ready_in=0 throughout; handshake on cycle 6 -> ready_in=1 the next cycle.
REQ-034 SHALL cover: rst pulsed at accept+10 -> no valid_out for that vertex; outputs 0; a following vertex w=0x00010000, x=0x00030000 -> x_ndc=0x00030000 at its accept+35.
REQ-035 SHALL cover: w=0x00000001, x=0x00020000 -> recip=0x7FFFFFFF; x_ndc=0x7FFFFFFF with PERSP_DIVIDE_SATURATE_EN, 0xFFFFFFFE without.
